// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch port (F, read-only)
// and the load/store data port (D). Each grant lasts one cycle; results come back
// registered with a one-cycle ack pulse. Round-robin on ties, optional write
// protection of the low program region for D writes.
module mem_port_arbiter #(
   parameter int BITS_DATA  = 32,
   parameter int BITS_ADDR  = 16,
   parameter int PROT_LIMIT = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 f_req,
   input  logic [BITS_ADDR-1:0] f_addr,
   output logic                 f_ack,
   output logic [BITS_DATA-1:0] f_rdata,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [BITS_ADDR-1:0] d_addr,
   input  logic [BITS_DATA-1:0] d_wdata,
   output logic                 d_ack,
   output logic [BITS_DATA-1:0] d_rdata,
   output logic                 d_err,
   output logic [BITS_ADDR-1:0] mem_address,
   output logic [BITS_DATA-1:0] mem_data_in,
   output logic                 mem_write,
   input  logic [BITS_DATA-1:0] mem_data_out
);

   typedef enum logic [1:0] {
      IDLE,
      GNT_F,
      GNT_D
   } state_t;

   localparam bit                 PROT_EN    = (PROT_LIMIT != 0);
   localparam logic [BITS_ADDR:0] PROT_BOUND = (BITS_ADDR + 1)'(PROT_LIMIT);

   state_t               state;
   logic                 last_grant_d;
   logic [BITS_ADDR-1:0] addr_lat;
   logic                 we_lat;
   logic [BITS_DATA-1:0] wdata_lat;

   logic                 f_elig;
   logic                 d_elig;
   logic                 pick_d;
   logic                 blocked;

   // A port may not be re-granted while its own grant cycle or its ack is still
   // in progress; ties go to the port that was not served last.
   always_comb begin
      f_elig = f_req && (state != GNT_F) && !f_ack;
      d_elig = d_req && (state != GNT_D) && !d_ack;
      pick_d = d_elig;
      if (f_elig && d_elig) begin
         pick_d = !last_grant_d;
      end
   end

   // A latched D write into the protected low region is suppressed and reported.
   always_comb begin
      blocked = PROT_EN && we_lat && ({1'b0, addr_lat} < PROT_BOUND);
   end

   // Memory bus carries the latched operands only while a grant is active.
   always_comb begin
      mem_address = '0;
      mem_data_in = '0;
      if (state != IDLE) begin
         mem_address = addr_lat;
         mem_data_in = wdata_lat;
      end
   end

   // Write strobe is gated by reset so an in-flight write is aborted immediately.
   always_comb begin
      mem_write = reset_n && (state == GNT_D) && we_lat && !blocked;
   end

   // Grant FSM: capture results of the ending grant and choose the next one.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         last_grant_d <= 1'b1;
         addr_lat     <= '0;
         we_lat       <= 1'b0;
         wdata_lat    <= '0;
         f_ack        <= 1'b0;
         d_ack        <= 1'b0;
         d_err        <= 1'b0;
         f_rdata      <= '0;
         d_rdata      <= '0;
      end else begin
         f_ack <= (state == GNT_F);
         d_ack <= (state == GNT_D);
         d_err <= (state == GNT_D) && blocked;
         if (state == GNT_F) begin
            f_rdata <= mem_data_out;
         end
         if (state == GNT_D) begin
            d_rdata <= mem_data_out;
         end
         if (f_elig || d_elig) begin
            if (pick_d) begin
               state        <= GNT_D;
               addr_lat     <= d_addr;
               we_lat       <= d_we;
               wdata_lat    <= d_wdata;
               last_grant_d <= 1'b1;
            end else begin
               state        <= GNT_F;
               addr_lat     <= f_addr;
               we_lat       <= 1'b0;
               wdata_lat    <= '0;
               last_grant_d <= 1'b0;
            end
         end else begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a bench-owned memory, a transaction
// level reference model and directed plus randomized request traffic.
module tb_mem_port_arbiter;

   localparam int PROT = 16;

   logic        clk;
   logic        reset_n;
   logic        f_req;
   logic [15:0] f_addr;
   logic        f_ack;
   logic [31:0] f_rdata;
   logic        d_req;
   logic        d_we;
   logic [15:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        d_err;
   logic [15:0] mem_address;
   logic [31:0] mem_data_in;
   logic        mem_write;
   logic [31:0] mem_data_out;

   logic [31:0] mem [0:65535];

   int          compared;
   int          mismatched;

   // Reference model state: edge counter, last grant edge per port, pending grant.
   int          edge_n;
   int          f_last;
   int          d_last;
   bit          last_was_d;
   int          m_gnt;
   logic [15:0] m_addr;
   logic        m_we;
   logic [31:0] m_wdata;
   logic        exp_f_ack;
   logic        exp_d_ack;
   logic        exp_d_err;
   logic [31:0] exp_f_rdata;
   logic [31:0] exp_d_rdata;
   logic [31:0] ref_mem [int];
   int          last_ack_port;

   mem_port_arbiter #(
      .BITS_DATA (32),
      .BITS_ADDR (16),
      .PROT_LIMIT(PROT)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .f_req       (f_req),
      .f_addr      (f_addr),
      .f_ack       (f_ack),
      .f_rdata     (f_rdata),
      .d_req       (d_req),
      .d_we        (d_we),
      .d_addr      (d_addr),
      .d_wdata     (d_wdata),
      .d_ack       (d_ack),
      .d_rdata     (d_rdata),
      .d_err       (d_err),
      .mem_address (mem_address),
      .mem_data_in (mem_data_in),
      .mem_write   (mem_write),
      .mem_data_out(mem_data_out)
   );

   assign mem_data_out = mem[mem_address];

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory: preloaded image, asynchronous read, write on the falling edge.
   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
      mem[0] = 32'h0900000D;
      mem[5] = 32'hA5A50005;
      forever begin
         @(negedge clk);
         if (mem_write) mem[mem_address] = mem_data_in;
      end
   end

   function automatic logic [31:0] refRead(input logic [15:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return 32'h0;
   endfunction

   function automatic logic [15:0] randAddr();
      if ($urandom_range(0, 3) == 0) return 16'h8000 + 16'($urandom_range(0, 7));
      return 16'($urandom_range(0, 31));
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Predict the effect of the coming rising edge from the inputs presented to it.
   task automatic modelEdge();
      bit f_ok;
      bit d_ok;
      bit pick_d;
      bit blk;
      if (!reset_n) begin
         exp_f_ack   = 1'b0;
         exp_d_ack   = 1'b0;
         exp_d_err   = 1'b0;
         exp_f_rdata = 32'h0;
         exp_d_rdata = 32'h0;
         m_gnt       = 0;
         m_addr      = 16'h0;
         m_we        = 1'b0;
         m_wdata     = 32'h0;
         last_was_d  = 1'b1;
         f_last      = -100;
         d_last      = -100;
      end else begin
         exp_f_ack = (m_gnt == 1);
         exp_d_ack = (m_gnt == 2);
         exp_d_err = 1'b0;
         if (m_gnt == 1) exp_f_rdata = refRead(m_addr);
         if (m_gnt == 2) begin
            blk = m_we && (int'(m_addr) < PROT);
            if (m_we && !blk) ref_mem[int'(m_addr)] = m_wdata;
            exp_d_rdata = refRead(m_addr);
            exp_d_err   = blk;
         end
         f_ok   = f_req && (edge_n - f_last >= 3);
         d_ok   = d_req && (edge_n - d_last >= 3);
         pick_d = (f_ok && d_ok) ? !last_was_d : d_ok;
         if (f_ok || d_ok) begin
            if (pick_d) begin
               m_gnt      = 2;
               m_addr     = d_addr;
               m_we       = d_we;
               m_wdata    = d_wdata;
               d_last     = edge_n;
               last_was_d = 1'b1;
            end else begin
               m_gnt      = 1;
               m_addr     = f_addr;
               m_we       = 1'b0;
               m_wdata    = 32'h0;
               f_last     = edge_n;
               last_was_d = 1'b0;
            end
         end else begin
            m_gnt = 0;
         end
      end
      edge_n++;
   endtask

   // Advance one clock edge and compare every output against the model.
   task automatic tick();
      logic exp_wr;
      modelEdge();
      @(posedge clk);
      #1;
      exp_wr = reset_n && (m_gnt == 2) && m_we && !(int'(m_addr) < PROT);
      checkOutput("f_ack", 32'(f_ack), 32'(exp_f_ack));
      checkOutput("d_ack", 32'(d_ack), 32'(exp_d_ack));
      checkOutput("d_err", 32'(d_err), 32'(exp_d_err));
      checkOutput("f_rdata", f_rdata, exp_f_rdata);
      checkOutput("d_rdata", d_rdata, exp_d_rdata);
      checkOutput("mem_write", 32'(mem_write), 32'(exp_wr));
      checkOutput("mem_address", 32'(mem_address), (m_gnt == 0) ? 32'h0 : 32'(m_addr));
      if (m_gnt != 1) checkOutput("mem_data_in", mem_data_in, (m_gnt == 0) ? 32'h0 : m_wdata);
   endtask

   // Hold unacknowledged requests; on ack or when free, issue a new one by chance.
   task automatic applyStimulus(input int f_pct, input int d_pct, input int wr_pct);
      if (!f_req || exp_f_ack) begin
         f_req  = ($urandom_range(0, 99) < f_pct);
         f_addr = randAddr();
      end
      if (!d_req || exp_d_ack) begin
         d_req   = ($urandom_range(0, 99) < d_pct);
         d_we    = ($urandom_range(0, 99) < wr_pct);
         d_addr  = randAddr();
         d_wdata = $urandom;
      end
   endtask

   // Directed scenarios followed by randomized traffic and a final memory sweep.
   initial begin
      compared      = 0;
      mismatched    = 0;
      edge_n        = 0;
      f_last        = -100;
      d_last        = -100;
      last_was_d    = 1'b1;
      m_gnt         = 0;
      m_addr        = 16'h0;
      m_we          = 1'b0;
      m_wdata       = 32'h0;
      exp_f_ack     = 1'b0;
      exp_d_ack     = 1'b0;
      exp_d_err     = 1'b0;
      exp_f_rdata   = 32'h0;
      exp_d_rdata   = 32'h0;
      last_ack_port = 0;
      ref_mem[0]    = 32'h0900000D;
      ref_mem[5]    = 32'hA5A50005;
      reset_n = 1'b0;
      f_req   = 1'b0;
      f_addr  = 16'h0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = 16'h0;
      d_wdata = 32'h0;
      tick();
      tick();

      $display("[TB] fetch after reset");
      reset_n = 1'b1;
      f_req   = 1'b1;
      f_addr  = 16'h0000;
      tick();
      checkOutput("t1_no_early_ack", 32'(f_ack), 32'h0);
      tick();
      checkOutput("t1_ack", 32'(f_ack), 32'h1);
      checkOutput("t1_rdata", f_rdata, 32'h0900000D);
      f_req = 1'b0;
      tick();
      checkOutput("t1_ack_width", 32'(f_ack), 32'h0);

      $display("[TB] data write then read back");
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 16'h8000;
      d_wdata = 32'hDEADBEEF;
      tick();
      checkOutput("t2_write_on", 32'(mem_write), 32'h1);
      tick();
      checkOutput("t2_write_off", 32'(mem_write), 32'h0);
      checkOutput("t2_write_ack", 32'(d_ack), 32'h1);
      d_we    = 1'b0;
      d_wdata = 32'h0;
      tick();
      tick();
      tick();
      checkOutput("t2_read_ack", 32'(d_ack), 32'h1);
      checkOutput("t2_read_data", d_rdata, 32'hDEADBEEF);
      checkOutput("t2_read_err", 32'(d_err), 32'h0);
      d_req = 1'b0;
      tick();

      $display("[TB] simultaneous requests after reset");
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      f_req   = 1'b1;
      f_addr  = 16'h0003;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 16'h8000;
      tick();
      checkOutput("t3_first_is_f", 32'(mem_address), 32'h0003);
      tick();
      checkOutput("t3_then_d", 32'(mem_address), 32'h8000);
      checkOutput("t3_f_ack", 32'(f_ack), 32'h1);
      applyStimulus(0, 0, 0);
      tick();
      checkOutput("t3_d_ack", 32'(d_ack), 32'h1);
      applyStimulus(0, 0, 0);
      tick();

      $display("[TB] both ports saturated");
      f_req = 1'b1;
      f_addr = randAddr();
      d_req = 1'b1;
      d_we = 1'b0;
      d_addr = randAddr();
      for (int c = 0; c < 20; c++) begin
         tick();
         if (f_ack || d_ack) begin
            checkOutput("t4_single_ack", 32'(f_ack & d_ack), 32'h0);
            if (last_ack_port != 0)
               checkOutput("t4_alternate", f_ack ? 32'd1 : 32'd2, (last_ack_port == 1) ? 32'd2 : 32'd1);
            last_ack_port = f_ack ? 1 : 2;
         end
         applyStimulus(100, 100, 50);
      end
      f_req = 1'b0;
      d_req = 1'b0;
      repeat (4) begin
         tick();
         applyStimulus(0, 0, 0);
      end

      $display("[TB] protected region writes");
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 16'h0005;
      d_wdata = 32'h00001234;
      tick();
      checkOutput("t5_no_write", 32'(mem_write), 32'h0);
      tick();
      checkOutput("t5_ack", 32'(d_ack), 32'h1);
      checkOutput("t5_err", 32'(d_err), 32'h1);
      d_req = 1'b0;
      tick();
      checkOutput("t5_err_clear", 32'(d_err), 32'h0);
      checkOutput("t5_mem5", mem[5], 32'hA5A50005);
      for (int k = 0; k < 2; k++) begin
         d_req   = 1'b1;
         d_we    = 1'b1;
         d_addr  = (k == 0) ? 16'd16 : 16'd15;
         d_wdata = $urandom;
         repeat (3) tick();
         d_req = 1'b0;
         tick();
      end

      $display("[TB] reset during data write");
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 16'h8001;
      d_wdata = 32'hCAFEF00D;
      tick();
      checkOutput("t6_write_armed", 32'(mem_write), 32'h1);
      reset_n = 1'b0;
      d_req   = 1'b0;
      #1;
      checkOutput("t6_write_aborted", 32'(mem_write), 32'h0);
      tick();
      checkOutput("t6_no_ack", 32'(d_ack), 32'h0);
      checkOutput("t6_d_rdata", d_rdata, 32'h0);
      reset_n = 1'b1;
      tick();
      checkOutput("t6_still_no_ack", 32'(d_ack), 32'h0);
      checkOutput("t6_mem_untouched", mem[16'h8001], 32'h0);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 400; c++) begin
         tick();
         applyStimulus(50, 50, 50);
      end
      repeat (6) begin
         tick();
         applyStimulus(0, 0, 0);
      end
      for (int a = 0; a < 32; a++) checkOutput("sweep_low", mem[a], refRead(16'(a)));
      for (int a = 0; a < 8; a++) checkOutput("sweep_high", mem[32'h8000 + a], refRead(16'h8000 + 16'(a)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
